wb_commit_stage: RTL

//  Registered writeback stage for the LA32 pipeline. Holds one MEM->WB entry and waits for late load data.

---
 rtl/wb_commit_stage_pkg.sv | 27 ++
 rtl/wb_commit_stage_load_extract.sv | 49 ++++
 rtl/wb_commit_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the LA32 writeback stage: op codes, access sizes and WB FSM states.
package wb_commit_stage_pkg;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_WAIT   = 2'd1,
        WB_COMMIT = 2'd2
    } wb_state_e;

    localparam logic [1:0] ACCESS_SZ_BYTE = 2'd0;
    localparam logic [1:0] ACCESS_SZ_HALF = 2'd1;
    localparam logic [1:0] ACCESS_SZ_WORD = 2'd2;

    localparam logic [7:0] OP_ADD     = 8'h01;
    localparam logic [7:0] OP_BL      = 8'h02;
    localparam logic [7:0] OP_LD      = 8'h10;
    localparam logic [7:0] OP_LDU     = 8'h11;
    localparam logic [7:0] OP_LL      = 8'h12;
    localparam logic [7:0] OP_RDCNTVL = 8'h20;
    localparam logic [7:0] OP_RDCNTVH = 8'h21;
    localparam logic [7:0] OP_RDCNTID = 8'h22;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LD) || (op == OP_LDU) || (op == OP_LL);
    endfunction

endpackage

// File: rtl/wb_commit_stage_load_extract.sv
// Combinational sub-word load lane extraction with sign or zero extension.
module wb_commit_stage_load_extract
    import wb_commit_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata,
    input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
    input  logic [1:0]                   sz,
    input  logic                         sext,
    output logic [DATA_W-1:0]            data
);
    localparam int AL_W = $clog2(DATA_W/8);
    // Halfword lanes are naturally aligned, so the lowest offset bit is dropped.
    localparam logic [AL_W-1:0] HALF_MASK = ~AL_W'(1);

    logic [AL_W+2:0] byte_sh_s;
    logic [AL_W+2:0] half_sh_s;
    logic [7:0]      byte_lane_s;
    logic [15:0]     half_lane_s;

    assign byte_sh_s   = {addr_lo, 3'b000};
    assign half_sh_s   = {addr_lo & HALF_MASK, 3'b000};
    assign byte_lane_s = 8'(rdata >> byte_sh_s);
    assign half_lane_s = 16'(rdata >> half_sh_s);

    // Select the lane by access size and extend it to the full data width
    always_comb begin
        data = rdata;
        case (sz)
            ACCESS_SZ_BYTE: begin
                if (sext) begin
                    data = DATA_W'($signed(byte_lane_s));
                end else begin
                    data = DATA_W'(byte_lane_s);
                end
            end
            ACCESS_SZ_HALF: begin
                if (sext) begin
                    data = DATA_W'($signed(half_lane_s));
                end else begin
                    data = DATA_W'(half_lane_s);
                end
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// LA32 writeback stage: holds one MEM->WB entry, waits for late load data, owns the stable counter.
// Optional commit trace ports are enabled by defining WB_DEBUG_TRACE_EN.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 8,
    parameter int CNT_W  = 64,
    parameter int RA_REG = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_valid,
    output logic                         wb_allowin,
    input  logic [OP_W-1:0]              mem_op,
    input  logic                         mem_rf_we,
    input  logic [REG_AW-1:0]            mem_reg_d,
    input  logic [DATA_W-1:0]            mem_exe_out,
    input  logic [1:0]                   mem_sz,
    input  logic [$clog2(DATA_W/8)-1:0]  mem_addr_lo,
    input  logic [31:0]                  mem_pc,
    input  logic                         data_ok,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [31:0]                  csr_tid,
    input  logic                         wb_flush,
    output logic                         rf_we,
    output logic [REG_AW-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         fwd_valid,
    output logic                         fwd_busy
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [REG_AW-1:0]            debug_wb_rf_wnum,
    output logic [DATA_W-1:0]            debug_wb_rf_wdata
`endif
);
    localparam int AL_W = $clog2(DATA_W/8);

    wb_state_e           state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [OP_W-1:0]     ent_op_r;
    logic [1:0]          ent_sz_r;
    logic [AL_W-1:0]     ent_alo_r;
    logic                ent_live_r;
    logic                rf_we_r;
    logic [REG_AW-1:0]   rf_waddr_r;
    logic [DATA_W-1:0]   rf_wdata_r;
    logic                fwd_valid_r;
    logic                fwd_busy_r;

    logic                capture_s;
    logic [REG_AW-1:0]   cap_waddr_s;
    logic                cap_live_s;
    logic [DATA_W-1:0]   cap_data_s;
    logic [DATA_W-1:0]   late_data_s;
    logic [1:0]          ext_sz_s;
    logic [AL_W-1:0]     ext_alo_s;
    logic                ext_sext_s;
    logic [DATA_W-1:0]   ext_data_s;

    assign wb_allowin  = (state_r != WB_WAIT) && !wb_flush;
    assign capture_s   = mem_valid && wb_allowin;
    assign cap_waddr_s = (mem_op == OP_W'(OP_BL)) ? REG_AW'(RA_REG) : mem_reg_d;
    // Writes to r0 are dropped at capture so they never reach the regfile or forwarding bus.
    assign cap_live_s  = mem_rf_we && (cap_waddr_s != '0);
    assign late_data_s = (ent_op_r == OP_W'(OP_LL)) ? rdata : ext_data_s;

    // Extraction inputs come from the held entry while waiting, else from the incoming entry
    always_comb begin
        ext_sz_s   = mem_sz;
        ext_alo_s  = mem_addr_lo;
        ext_sext_s = (mem_op == OP_W'(OP_LD));
        if (state_r == WB_WAIT) begin
            ext_sz_s   = ent_sz_r;
            ext_alo_s  = ent_alo_r;
            ext_sext_s = (ent_op_r == OP_W'(OP_LD));
        end else begin
            ext_sz_s   = mem_sz;
            ext_alo_s  = mem_addr_lo;
            ext_sext_s = (mem_op == OP_W'(OP_LD));
        end
    end

    wb_commit_stage_load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .rdata   (rdata),
        .addr_lo (ext_alo_s),
        .sz      (ext_sz_s),
        .sext    (ext_sext_s),
        .data    (ext_data_s)
    );

    // Final writeback value for an entry that completes on its capture cycle
    always_comb begin
        cap_data_s = mem_exe_out;
        case (mem_op)
            OP_W'(OP_LD),
            OP_W'(OP_LDU):      cap_data_s = ext_data_s;
            OP_W'(OP_LL):       cap_data_s = rdata;
            OP_W'(OP_RDCNTVL):  cap_data_s = DATA_W'(cnt_r[31:0]);
            OP_W'(OP_RDCNTVH):  cap_data_s = DATA_W'(cnt_r[CNT_W-1:32]);
            OP_W'(OP_RDCNTID):  cap_data_s = DATA_W'(csr_tid);
            default:            cap_data_s = mem_exe_out;
        endcase
    end

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] ent_pc_r;
`else
    logic unused_pc_s;
    assign unused_pc_s = ^mem_pc;
`endif

    // FSM, entry capture, free-running counter and registered writeback outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= WB_IDLE;
            cnt_r       <= '0;
            ent_op_r    <= '0;
            ent_sz_r    <= 2'd0;
            ent_alo_r   <= '0;
            ent_live_r  <= 1'b0;
            rf_we_r     <= 1'b0;
            rf_waddr_r  <= '0;
            rf_wdata_r  <= '0;
            fwd_valid_r <= 1'b0;
            fwd_busy_r  <= 1'b0;
`ifdef WB_DEBUG_TRACE_EN
            ent_pc_r    <= 32'd0;
`endif
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (wb_flush) begin
                state_r     <= WB_IDLE;
                rf_we_r     <= 1'b0;
                fwd_valid_r <= 1'b0;
                fwd_busy_r  <= 1'b0;
            end else if (capture_s) begin
                ent_op_r    <= mem_op;
                ent_sz_r    <= mem_sz;
                ent_alo_r   <= mem_addr_lo;
                ent_live_r  <= cap_live_s;
                rf_waddr_r  <= cap_waddr_s;
                fwd_valid_r <= cap_live_s;
`ifdef WB_DEBUG_TRACE_EN
                ent_pc_r    <= mem_pc;
`endif
                if (is_load(8'(mem_op)) && !data_ok) begin
                    state_r    <= WB_WAIT;
                    rf_we_r    <= 1'b0;
                    fwd_busy_r <= cap_live_s;
                end else begin
                    state_r    <= WB_COMMIT;
                    rf_wdata_r <= cap_data_s;
                    rf_we_r    <= cap_live_s;
                    fwd_busy_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    WB_WAIT: begin
                        if (data_ok) begin
                            state_r    <= WB_COMMIT;
                            rf_wdata_r <= late_data_s;
                            rf_we_r    <= ent_live_r;
                            fwd_busy_r <= 1'b0;
                        end else begin
                            state_r    <= WB_WAIT;
                            rf_we_r    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r     <= WB_IDLE;
                        rf_we_r     <= 1'b0;
                        fwd_valid_r <= 1'b0;
                        fwd_busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rf_we     = rf_we_r;
    assign rf_waddr  = rf_waddr_r;
    assign rf_wdata  = rf_wdata_r;
    assign fwd_valid = fwd_valid_r;
    assign fwd_busy  = fwd_busy_r;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = ent_pc_r;
    assign debug_wb_rf_we    = {4{rf_we_r}};
    assign debug_wb_rf_wnum  = rf_waddr_r;
    assign debug_wb_rf_wdata = rf_wdata_r;
`endif

endmodule
